spi_master_tx: RTL



---
 rtl/spi_master_pkg.sv | 15 +
 rtl/spi_master_tx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master shifters (tx now, rx later).
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSMIT = 2'd1,
    STALL    = 2'd2
  } state_t;

  localparam int STEP_STD        = 1;
  localparam int STEP_QUAD       = 4;
  localparam int WORD_EDGES_STD  = 32;
  localparam int WORD_EDGES_QUAD = 8;

endpackage

// File: rtl/spi_master_tx.sv
// SPI transmit shifter: pulls FIFO words, shifts them out on the SCLK falling
// strobe in 1-bit or 4-bit mode, and gates SCLK while the FIFO is empty.
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tx_edge,
  input  logic              en_quad_in,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [WORD_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              clk_en_o,
  output logic              tx_done,
  output logic              sdo0,
  output logic              sdo1,
  output logic              sdo2,
  output logic              sdo3
);

  localparam int LW = $clog2(WORD_W);

  state_t             state;
  logic [WORD_W-1:0]  shift_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   target;
  logic               quad;

  logic [CNT_W-1:0]   step;
  logic [CNT_W-1:0]   next_cnt;
  logic               last;
  logic               boundary;
  logic [WORD_W-1:0]  shift_nxt;

  assign step      = quad ? CNT_W'(STEP_QUAD) : CNT_W'(STEP_STD);
  assign next_cnt  = bit_cnt + step;
  // Compare against the current target register, so a same-cycle update
  // only affects the following edge.
  assign last      = (next_cnt >= target);
  assign boundary  = (next_cnt[LW-1:0] == '0);
  assign shift_nxt = quad ? {shift_reg[WORD_W-5:0], 4'b0000}
                          : {shift_reg[WORD_W-2:0], 1'b0};

  always_comb begin
    data_ready = 1'b0;
    if (rstn) begin
      case (state)
        IDLE:     data_ready = en && (target != '0) && data_valid;
        TRANSMIT: data_ready = tx_edge && !last && boundary && data_valid;
        STALL:    data_ready = data_valid;
        default:  data_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      target    <= '0;
      quad      <= 1'b0;
      clk_en_o  <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (counter_in_upd) target <= counter_in;
      case (state)
        IDLE: begin
          if (en) begin
            if (target == '0) begin
              tx_done <= 1'b1;
            end else if (data_valid) begin
              quad      <= en_quad_in;
              shift_reg <= data;
              bit_cnt   <= '0;
              clk_en_o  <= 1'b1;
              state     <= TRANSMIT;
            end else begin
              quad     <= en_quad_in;
              bit_cnt  <= '0;
              clk_en_o <= 1'b0;
              state    <= STALL;
            end
          end
        end
        TRANSMIT: begin
          if (tx_edge) begin
            bit_cnt <= next_cnt;
            if (last) begin
              shift_reg <= shift_nxt;
              tx_done   <= 1'b1;
              clk_en_o  <= 1'b0;
              state     <= IDLE;
            end else if (boundary) begin
              if (data_valid) begin
                shift_reg <= data;
              end else begin
                shift_reg <= shift_nxt;
                clk_en_o  <= 1'b0;
                state     <= STALL;
              end
            end else begin
              shift_reg <= shift_nxt;
            end
          end
        end
        STALL: begin
          if (data_valid) begin
            shift_reg <= data;
            clk_en_o  <= 1'b1;
            state     <= TRANSMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The mode flag only changes in IDLE, so these muxes are static mid-transfer.
  assign sdo0 = quad ? shift_reg[WORD_W-4] : shift_reg[WORD_W-1];
  assign sdo1 = quad & shift_reg[WORD_W-3];
  assign sdo2 = quad & shift_reg[WORD_W-2];
  assign sdo3 = quad & shift_reg[WORD_W-1];

endmodule
